sbox_layer_seq: RTL and testbench
=================================

Name: sbox_layer_seq

Overview:
- Parametrised, time-multiplexed PRESENT substitution layer.
- Applies the 4-bit S-box, or its inverse, to all 16 nibbles of a 64-bit state using LANES parallel S-boxes over 16/LANES cycles.
- Trades area for latency for round-iterative and low-area cipher cores.
- Uses a valid/ready handshake on input and output, so it drops into pipelined or FSM-driven datapaths.

Parameters:
- LANES, 4, number of parallel S-boxes. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- STEPS (localparam), 16/LANES, number of substitution cycles per block.
- CNT_W (localparam), max(1, $clog2(STEPS)), step counter width.

Ports:
- clk_i  input  1  clock. One clock domain; all logic is rising-edge.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  data_i and inv_i are valid.
- in_ready_o  output  1  block can accept a new input this cycle.
- inv_i  input  1  0 = forward S-box (encrypt); 1 = inverse S-box (decrypt).
- data_i  input  64  state to substitute.
- out_valid_o  output  1  data_o holds a completed result.
- out_ready_i  input  1  consumer accepts data_o.
- data_o  output  64  substituted state.

Behaviour:
- States:
  - IDLE: empty.
  - BUSY: substituting.
  - DONE: result held.
- Reset (rst_i=1 at a rising edge): state=IDLE, internal state register r=0, counter=0, mode=0. Resulting outputs: out_valid_o=0, data_o=0, in_ready_o=1.
- Reset mid-operation: the in-flight block is discarded and no output is produced.
- in_ready_o = (state==IDLE) | (state==DONE & out_ready_i). This is combinational from out_ready_i and gives back-to-back acceptance.
- Accept: in_valid_i & in_ready_o at edge t.
  - r <= data_i; mode <= inv_i; counter <= 0; state <= BUSY.
  - If state was DONE, the old result is consumed at the same edge.
- BUSY, each edge:
  - r <= {SB(r[W-1:0]), r[63:W]}, where W = LANES*4.
  - SB applies the forward or inverse S-box to each nibble independently, selected by the latched mode.
  - The counter increments.
  - On the edge where counter==STEPS-1, state <= DONE.
- After STEPS rotations every nibble has been substituted exactly once and nibble order is restored; no final permutation is needed.
- Latency: accepted at edge t, out_valid_o=1 after edge t+STEPS. For LANES=16, STEPS=1.
- DONE:
  - out_valid_o=1 and data_o=r, held stable until out_ready_i=1.
  - Output handshake without a new input: state <= IDLE, out_valid_o <= 0.
  - Output handshake together with in_valid_i: the new block is accepted at the same edge.
- out_valid_o=0 in IDLE and BUSY. data_o=r always, so it is undefined for consumers unless out_valid_o=1.
- inv_i and data_i are sampled only at accept; changes while BUSY are ignored.
- Throughput: one block per STEPS+1 cycles with a continuously ready consumer.

Optional Feature:
- Macro: SBOX_LAYER_INV_EN.
- Defined:
  - The inverse S-box datapath is instantiated.
  - inv_i selects forward or inverse per block, as described above.
- Undefined:
  - No inverse logic is built and the mode register is removed.
  - inv_i is ignored and only forward substitution is applied.
  - Ports are unchanged.

Decomposition:
- Package present_pkg:
  - SBOX and SBOX_INV 16x4-bit constant tables.
  - typedef state_t (logic [63:0]).
  - typedef nibble_t (logic [3:0]).
  - enum sbl_state_e {IDLE, BUSY, DONE}.
- Sub-module sbox_dual: one nibble, inputs data_i[3:0] and inv_i, output data_o[3:0]. It contains the forward/inverse lookup, and its inverse branch is compiled under SBOX_LAYER_INV_EN.
- The top level generates LANES instances of sbox_dual.

Test Plan:
- LANES=4, inv_i=0, data_i=64'h0 -> out_valid_o rises 4 edges after accept, data_o=64'hCCCCCCCCCCCCCCCC.
- LANES=4, inv_i=0, data_i=64'h0123456789ABCDEF -> data_o=64'hC56B90AD3EF84712.
- SBOX_LAYER_INV_EN defined, inv_i=1, data_i=64'hC56B90AD3EF84712 -> data_o=64'h0123456789ABCDEF. Repeat for LANES=1 (latency 16) and LANES=16 (latency 1).
- Backpressure: out_ready_i=0 for 5 cycles in DONE -> data_o and out_valid_o stable, in_ready_o=0. Raise out_ready_i with in_valid_i=1 -> result consumed and the new block accepted at the same edge.
- rst_i asserted at the 2nd BUSY cycle -> next cycle out_valid_o=0, data_o=0, in_ready_o=1. The aborted result never appears.
- Random 1000 blocks with random valid/ready gaps, all LANES values -> results match a reference-model S-box layer, and no block is lost or duplicated.

Source files
------------

// File: rtl/present_pkg.sv
// PRESENT S-box tables and shared types for the sequential substitution layer.
package present_pkg;

   typedef logic [63:0] state_t;
   typedef logic [3:0]  nibble_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } sbl_state_e;

   // Forward S-box; entry x sits at index x (listed from index 15 down to 0).
   localparam logic [15:0][3:0] SBOX = {
      4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
      4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
   };

   // Inverse S-box; entry y sits at index y (listed from index 15 down to 0).
   localparam logic [15:0][3:0] SBOX_INV = {
      4'hA, 4'h9, 4'h7, 4'h0, 4'h3, 4'h6, 4'h4, 4'hB,
      4'hD, 4'h2, 4'h1, 4'hC, 4'h8, 4'hF, 4'hE, 4'h5
   };

endpackage

// File: rtl/sbox_dual.sv
// One-nibble PRESENT S-box lookup. Inverse path present only when
// SBOX_LAYER_INV_EN is defined; otherwise inv_i is ignored.
module sbox_dual
   import present_pkg::*;
(
   input  nibble_t data_i,
   input  logic    inv_i,
   output nibble_t data_o
);

`ifdef SBOX_LAYER_INV_EN
   // Mode-selected forward or inverse lookup.
   assign data_o = inv_i ? SBOX_INV[data_i] : SBOX[data_i];
`else
   logic unused_inv;
   assign unused_inv = inv_i;

   // Forward-only lookup.
   assign data_o = SBOX[data_i];
`endif

endmodule

// File: rtl/sbox_layer_seq.sv
// Time-multiplexed PRESENT substitution layer: LANES S-boxes substitute the
// low nibbles of a 64-bit rotating register over 16/LANES cycles.
// Valid/ready on both sides. Optional inverse mode via SBOX_LAYER_INV_EN.
module sbox_layer_seq
   import present_pkg::*;
#(
   parameter int unsigned LANES = 4
)
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic        inv_i,
   input  logic [63:0] data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [63:0] data_o
);

   localparam int unsigned STEPS = 16 / LANES;
   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int unsigned W     = LANES * 4;

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("sbox_layer_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   sbl_state_e       state_q, state_d;
   state_t           r_q, r_d, rot_next;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     sb_out;
   logic             mode_q;
   logic             accept;

`ifdef SBOX_LAYER_INV_EN
   logic mode_d;
`else
   logic unused_inv;
   assign unused_inv = inv_i;
   assign mode_q     = 1'b0;
`endif

   // Parallel S-boxes over the low W bits of the state register.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sbox_dual u_sbox (
         .data_i (r_q[4*i +: 4]),
         .inv_i  (mode_q),
         .data_o (sb_out[4*i +: 4])
      );
   end

   // Substituted nibbles enter at the top so order is restored after STEPS rotations.
   if (W == 64) begin : g_rot_full
      assign rot_next = sb_out;
   end else begin : g_rot_part
      assign rot_next = {sb_out, r_q[63:W]};
   end

   assign in_ready_o  = (state_q == IDLE) | ((state_q == DONE) & out_ready_i);
   assign accept      = in_valid_i & in_ready_o;
   assign out_valid_o = (state_q == DONE);
   assign data_o      = r_q;

   // Next-state, datapath and counter control.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
`ifdef SBOX_LAYER_INV_EN
      mode_d  = mode_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = BUSY;
               r_d     = data_i;
               cnt_d   = '0;
`ifdef SBOX_LAYER_INV_EN
               mode_d  = inv_i;
`endif
            end else if ((state_q == DONE) && out_ready_i) begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            r_d   = rot_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STEPS - 1)) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, data and counter registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         r_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SBOX_LAYER_INV_EN
   // Per-block direction latched at accept.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
      end
   end
`endif

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Bench for sbox_layer_seq: directed table (LANES=4), backpressure and
// mid-operation reset sequences, plus randomized traffic on every LANES value.
module tb_sbox_layer_seq;

   localparam int NB     = 200;
   localparam int MAXCYC = 30000;
`ifdef SBOX_LAYER_INV_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [3:0] sfwd [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
   logic [3:0] sinv [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                             4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

   // Reference: whole-state nibble-wise substitution.
   function automatic logic [63:0] ref_layer(input logic [63:0] d, input logic inv);
      logic [63:0] o;
      for (int i = 0; i < 16; i++) begin
         o[4*i +: 4] = (inv && INV_EN) ? sinv[d[4*i +: 4]] : sfwd[d[4*i +: 4]];
      end
      return o;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Directed DUT (LANES=4)
   logic        rst, in_valid, in_ready, inv, out_valid, out_ready;
   logic [63:0] data, data_o;

   sbox_layer_seq #(.LANES(4)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .inv_i       (inv),
      .data_i      (data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .data_o      (data_o)
   );

   // Called right after an accepting edge: counts edges until out_valid.
   task automatic wait_done(output int lat);
      int n = 0;
      do begin
         @(negedge clk);
         if (n == 0) begin
            in_valid  = 1'b0;
            out_ready = 1'b0;
            data      = ~data;
            inv       = ~inv;
         end
         n++;
      end while (!out_valid && n < 40);
      lat = n - 1;
   endtask

   typedef struct {
      logic        inv;
      logic [63:0] din;
      logic [63:0] dexp;
      int          lat;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int   lat;
      logic seen;
      logic [63:0] nb;

      vecs[0] = '{1'b0, 64'h0000000000000000, 64'hCCCCCCCCCCCCCCCC, 4};
      vecs[1] = '{1'b0, 64'h0123456789ABCDEF, 64'hC56B90AD3EF84712, 4};
      vecs[2] = '{1'b1, 64'hC56B90AD3EF84712,
                  INV_EN ? 64'h0123456789ABCDEF : 64'h40A8ECF7B1239D56, 4};
      vecs[3] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h2222222222222222, 4};
      vecs[4] = '{1'b1, 64'h0000000000000000,
                  INV_EN ? 64'h5555555555555555 : 64'hCCCCCCCCCCCCCCCC, 4};

      rst = 1'b1; in_valid = 1'b0; inv = 1'b0; data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_data_o", data_o, 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;

      // Table-driven blocks
      for (int v = 0; v < 5; v++) begin
         @(negedge clk);
         in_valid = 1'b1; inv = vecs[v].inv; data = vecs[v].din; out_ready = 1'b0;
         #1 chk($sformatf("in_ready_idle_%0d", v), 64'(in_ready), 64'd1);
         @(posedge clk);
         wait_done(lat);
         chk($sformatf("latency_%0d", v), 64'(lat), 64'(vecs[v].lat));
         chk($sformatf("data_%0d", v), data_o, vecs[v].dexp);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk($sformatf("popped_valid_%0d", v), 64'(out_valid), 64'd0);
         chk($sformatf("popped_ready_%0d", v), 64'(in_ready), 64'd1);
      end

      // Backpressure, then back-to-back accept with the pop
      @(negedge clk);
      in_valid = 1'b1; inv = 1'b0; data = 64'h0123456789ABCDEF; out_ready = 1'b0;
      @(posedge clk);
      wait_done(lat);
      chk("bp_latency", 64'(lat), 64'd4);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; data = 64'hFFFFFFFFFFFFFFFF;
         #1;
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_data", data_o, 64'hC56B90AD3EF84712);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      nb = 64'h0F1E2D3C4B5A6978;
      in_valid = 1'b1; inv = 1'b0; data = nb; out_ready = 1'b1;
      #1 chk("b2b_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      wait_done(lat);
      chk("b2b_latency", 64'(lat), 64'd4);
      chk("b2b_data", data_o, ref_layer(nb, 1'b0));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Reset during the second BUSY cycle
      in_valid = 1'b1; inv = 1'b0; data = 64'h0123456789ABCDEF;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_data_o", data_o, 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      chk("midrst_no_result", 64'(seen), 64'd0);

      wait (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done &&
            g_rnd[3].done && g_rnd[4].done);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Randomized traffic, one DUT per LANES value
   for (genvar k = 0; k < 5; k++) begin : g_rnd
      localparam int unsigned L = 32'd1 << k;

      logic        r_rst, r_in_valid, r_in_ready, r_inv, r_out_valid, r_out_ready;
      logic [63:0] r_data, r_data_o;
      logic [63:0] q [$];
      bit          done = 1'b0;

      sbox_layer_seq #(.LANES(L)) u_dut (
         .clk_i       (clk),
         .rst_i       (r_rst),
         .in_valid_i  (r_in_valid),
         .in_ready_o  (r_in_ready),
         .inv_i       (r_inv),
         .data_i      (r_data),
         .out_valid_o (r_out_valid),
         .out_ready_i (r_out_ready),
         .data_o      (r_data_o)
      );

      initial begin
         r_rst = 1'b1; r_in_valid = 1'b0; r_inv = 1'b0; r_data = '0; r_out_ready = 1'b0;
         repeat (3) @(negedge clk);
         r_rst = 1'b0;
         fork
            begin : drv
               int          n, cyc, gap;
               bit          pend;
               logic [63:0] d;
               logic        iv;
               n = 0; cyc = 0; gap = 0; pend = 1'b0; d = '0; iv = 1'b0;
               while (n < NB && cyc < MAXCYC) begin
                  @(negedge clk);
                  cyc++;
                  if (!pend) begin
                     if (gap > 0) begin
                        gap--;
                        r_in_valid = 1'b0;
                        r_data     = {$urandom, $urandom};
                        r_inv      = 1'($urandom);
                     end else begin
                        d          = {$urandom, $urandom};
                        iv         = 1'($urandom);
                        r_in_valid = 1'b1;
                        r_data     = d;
                        r_inv      = iv;
                        pend       = 1'b1;
                     end
                  end
                  #1;
                  if (r_in_valid && r_in_ready) begin
                     q.push_back(ref_layer(d, iv));
                     pend = 1'b0;
                     n++;
                     gap = int'($urandom_range(0, 3));
                  end
               end
               @(negedge clk);
               r_in_valid = 1'b0;
            end
            begin : mon
               int got, cyc;
               got = 0; cyc = 0;
               while (got < NB && cyc < MAXCYC) begin
                  @(negedge clk);
                  cyc++;
                  r_out_ready = ($urandom_range(0, 3) != 0);
                  #1;
                  if (r_out_valid && r_out_ready) begin
                     if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rnd_extra_L%0d: got unexpected %h expected none", L, r_data_o);
                     end else begin
                        chk($sformatf("rnd_data_L%0d", L), r_data_o, q.pop_front());
                     end
                     got++;
                  end
               end
               chk($sformatf("rnd_count_L%0d", L), 64'(got), 64'(NB));
            end
         join
         chk($sformatf("rnd_leftover_L%0d", L), 64'(q.size()), 64'd0);
         done = 1'b1;
      end
   end

endmodule
